// File: rtl/fb_pkg.sv
// fb_pkg: shared types and constants for the framebuffer reader.
package fb_pkg;
  typedef enum logic [1:0] {WAIT_SYNC, FETCH, DRAIN} state_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
  localparam int BYTES_PER_PIXEL = 4;
endpackage

// File: rtl/fb_out_fifo.sv
// fb_out_fifo: small synchronous pixel FIFO with flush; head is zero while empty.
module fb_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  always_comb begin
    empty = count == '0;
    full = count == CW'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge sys_clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fb_reader.sv
// fb_reader: Wishbone classic read master streaming the framebuffer in raster order
// into a small output FIFO, one read outstanding at a time.
module fb_reader
  import fb_pkg::*;
#(
  parameter int          HDISP = 800,
  parameter int          VDISP = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        frame_sync,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] err_cnt
);
  localparam int TOTAL = HDISP * VDISP;
  localparam int IW = $clog2(TOTAL);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t state;
  logic [IW-1:0] idx, idx_nxt;
  logic [CW-1:0] fifo_cnt;
  logic fifo_full, fifo_empty, term, flush, push, room;
  logic [31:0] push_data;

  assign wb_stb = wb_cyc;
  assign wb_we = 1'b0;
  assign wb_sel = WB_SEL_ALL;
  assign pix_valid = !fifo_empty;

  always_comb begin
    term = wb_cyc && (wb_ack || wb_err);
    idx_nxt = (idx == IW'(TOTAL - 1)) ? '0 : idx + 1'b1;
    flush = (state == FETCH && frame_sync && (!wb_cyc || term)) || (state == DRAIN && term);
    push = state == FETCH && term && !frame_sync;
    push_data = wb_ack ? wb_dat_i : 32'h0;
    room = !fifo_full && (fifo_cnt < CW'(BUF_DEPTH));
  end

  // a read is only issued once the buffer has a slot reserved for its data
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= WAIT_SYNC;
      wb_cyc <= 1'b0;
      wb_adr <= BASE_ADDR;
      idx <= '0;
      err_cnt <= '0;
    end else begin
      if (term && wb_err && !wb_ack && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      case (state)
        WAIT_SYNC: if (frame_sync) state <= FETCH;
        FETCH:
          if (flush) begin
            idx <= '0;
            wb_adr <= BASE_ADDR;
            wb_cyc <= 1'b0;
          end else if (frame_sync) state <= DRAIN;
          else if (term) begin
            idx <= idx_nxt;
            wb_adr <= BASE_ADDR + 32'(BYTES_PER_PIXEL) * 32'(idx_nxt);
            wb_cyc <= 1'b0;
          end else if (!wb_cyc && room) wb_cyc <= 1'b1;
        DRAIN:
          if (term) begin
            state <= FETCH;
            idx <= '0;
            wb_adr <= BASE_ADDR;
            wb_cyc <= 1'b0;
          end
        default: state <= WAIT_SYNC;
      endcase
    end
  end

  fb_out_fifo #(.DEPTH(BUF_DEPTH), .W(32)) u_fifo (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .push(push),
    .pop(pix_ready),
    .flush(flush),
    .din(push_data),
    .dout(pix_data),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );
endmodule
